// File: rtl/pcm_sched_pkg.sv
// Shared types and constants for the PCM sample-rate scheduler.
// The gain helper is only referenced when PCM_SOFTMUTE_EN is defined.
package pcm_sched_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int GAIN_W     = 7;
    localparam int GAIN_SHIFT = 6;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_t;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // (sample * gain) >>> 6 from a 23-bit signed product, truncated to the sample width.
    function automatic sample_t apply_gain(input sample_t s, input logic [GAIN_W-1:0] g);
        logic signed [SAMPLE_W+GAIN_W-1:0] s_x;
        logic signed [SAMPLE_W+GAIN_W-1:0] g_x;
        logic signed [SAMPLE_W+GAIN_W-1:0] prod;
        s_x  = (SAMPLE_W+GAIN_W)'(s);
        g_x  = (SAMPLE_W+GAIN_W)'($signed({1'b0, g}));
        prod = s_x * g_x;
        return prod[GAIN_SHIFT +: SAMPLE_W];
    endfunction

endpackage

// File: rtl/pcm_fs_nco.sv
// Fractional accumulator producing FS_NUM ticks every FS_DEN clocks.
// run=0 holds the accumulator at zero so the first tick lands ceil(FS_DEN/FS_NUM) cycles in.
module pcm_fs_nco #(
    parameter int FS_NUM = 49,
    parameter int FS_DEN = 82540
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int ACC_W = $clog2(FS_DEN + FS_NUM);
    localparam logic [ACC_W-1:0] NUM = ACC_W'(FS_NUM);
    localparam logic [ACC_W-1:0] DEN = ACC_W'(FS_DEN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             wrap;

    always_comb begin
        acc_sum = acc + NUM;
        wrap    = (acc_sum >= DEN);
        tick    = run && wrap;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            acc <= '0;
        end else if (wrap) begin
            acc <= acc_sum - DEN;
        end else begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/pcm_fs_scheduler.sv
// Audio sample scheduler: fs strobe generation, 2-entry sample buffer, mute and underrun.
// Define PCM_SOFTMUTE_EN for a 64-step gain ramp instead of hard mute.
module pcm_fs_scheduler
    import pcm_sched_pkg::*;
#(
    parameter int FS_NUM = 49,
    parameter int FS_DEN = 82540
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       mute,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_l,
    input  logic signed [SAMPLE_W-1:0] in_r,
    output logic                       pcm_fs,
    output logic signed [SAMPLE_W-1:0] pcm_l,
    output logic signed [SAMPLE_W-1:0] pcm_r,
    output logic                       underrun,
    input  logic                       underrun_clr,
    output logic                       running
);

    sched_state_t state;
    sched_state_t state_nxt;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    sample_t      buf_l [2];
    sample_t      buf_r [2];
    logic         nco_run;
    logic         fs_tick;
    logic         push;
    logic         pop;
    logic         slot;
    sample_t      out_l;
    sample_t      out_r;

    // Dropping enable also stops the accumulator, so a tick in that cycle never escapes.
    assign nco_run = (state == ST_RUN) && enable;

    pcm_fs_nco #(
        .FS_NUM (FS_NUM),
        .FS_DEN (FS_DEN)
    ) u_nco (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (nco_run),
        .tick    (fs_tick)
    );

    always_comb begin
        in_ready  = (state != ST_IDLE) && (count < 2'd2);
        running   = (state == ST_RUN);
        push      = in_valid && in_ready;
        pop       = fs_tick && (count != 2'd0);
        count_nxt = count + {1'b0, push} - {1'b0, pop};
        slot      = count[0] && !pop;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_PRIME;
            ST_PRIME: if (count_nxt == 2'd2) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!enable) state_nxt = ST_IDLE;
    end

`ifdef PCM_SOFTMUTE_EN
    logic [GAIN_W-1:0] gain;
    logic [GAIN_W-1:0] gain_nxt;

    // The gain stepped at this tick is the one applied to the sample it pops.
    always_comb begin
        if (mute) begin
            gain_nxt = (gain == '0) ? '0 : gain - 7'd1;
        end else begin
            gain_nxt = (gain == GAIN_MAX) ? GAIN_MAX : gain + 7'd1;
        end
        out_l = pop ? apply_gain(buf_l[0], gain_nxt) : '0;
        out_r = pop ? apply_gain(buf_r[0], gain_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !enable || (state == ST_IDLE)) begin
            gain <= GAIN_MAX;
        end else if (fs_tick) begin
            gain <= gain_nxt;
        end
    end
`else
    always_comb begin
        out_l = (pop && !mute) ? buf_l[0] : '0;
        out_r = (pop && !mute) ? buf_r[0] : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            pcm_fs   <= 1'b0;
            pcm_l    <= '0;
            pcm_r    <= '0;
            underrun <= 1'b0;
        end else begin
            state  <= state_nxt;
            pcm_fs <= fs_tick;
            count  <= enable ? count_nxt : 2'd0;
            if (!enable) begin
                pcm_l <= '0;
                pcm_r <= '0;
            end else if (fs_tick) begin
                pcm_l <= out_l;
                pcm_r <= out_r;
            end
            if (fs_tick && (count == 2'd0)) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // Entry 0 is always the oldest; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (pop) begin
            buf_l[0] <= buf_l[1];
            buf_r[0] <= buf_r[1];
        end
        if (push) begin
            buf_l[slot] <= in_l;
            buf_r[slot] <= in_r;
        end
    end

endmodule

// File: doc/pcm_fs_scheduler.md
# pcm_fs_scheduler

Single-clock audio sample scheduler in the video clock domain, placed between the PCM source and `hdmi_tx`. It generates the exact-average sample-rate strobe `pcm_fs` from the pixel clock with a fractional accumulator. It pulls stereo samples from an upstream valid/ready source into a 2-entry buffer and presents one sample per strobe. It also handles priming, underrun and mute, so the HDMI audio packetizer always sees a well-formed fs/data stream.

## Interface
- `FS_NUM`, 49: numerator of fs/clk ratio (default: 44.1 kHz from 74.286 MHz).
- `FS_DEN`, 82540: denominator of fs/clk ratio; `FS_NUM < FS_DEN`, both > 0.
- `clk`  in  1  video clock; all logic on rising edge.
- `reset_n`  in  1  reset; **synchronous, active-low**.
- `enable`  in  1  scheduler run request.
- `mute`  in  1  force silence at output.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  buffer can accept a sample.
- `in_l`, `in_r`  in  16 each  signed left/right sample.
- `pcm_fs`  out  1  one-cycle sample strobe to `hdmi_tx`.
- `pcm_l`, `pcm_r`  out  16 each  signed output samples.
- `underrun`  out  1  sticky: a strobe found the buffer empty.
- `underrun_clr`  in  1  clears `underrun`.
- `running`  out  1  high in RUN state.

## Operation
- Reset (`reset_n`=0 at an edge): state IDLE, accumulator 0, buffer empty. Outputs: `pcm_fs`=0, `pcm_l`/`pcm_r`=0, `underrun`=0, `running`=0, `in_ready`=0.
- **IDLE:** accumulator held at 0, no strobes, buffer flushed, `in_ready`=0. `enable`=1 moves to PRIME.
- **PRIME:** `in_ready`=1 while count<2, samples accepted. Count reaching 2 moves to RUN. No strobes.
- **RUN:** each cycle `acc += FS_NUM`. If the result is >= `FS_DEN`, subtract `FS_DEN` and tick.
  - Accumulator width is `$clog2(FS_DEN+FS_NUM)`; no overflow is permitted.
- **Tick with count>0:** pop the oldest entry into `pcm_l`/`pcm_r`, subject to mute.
- **Tick with count=0:** output 0/0, set `underrun`, remain in RUN.
- **Buffer:** 2-entry FIFO. `in_ready` = (state≠IDLE) && (count<2).
  - Push on `in_valid && in_ready`.
  - Push and pop in the same cycle at count=1 leaves count=1.
  - At count=0, a simultaneous push and tick is an underrun. The new sample is not bypassed; it is stored (count becomes 1).
- **`enable`=0 in any state:** IDLE next cycle, buffer flushed, `pcm_l`/`pcm_r` cleared to 0, an in-progress strobe is not issued.
- **Mute:** samples are still consumed at each tick; only the output value is affected (see Configuration).
- **`underrun_clr`:** clears `underrun` next cycle. If it coincides with a new underrun, set wins.

## Timing
- `pcm_fs`, `pcm_l`, `pcm_r` are registered. Data changes only in the cycle `pcm_fs`=1 and is held until the next strobe.
- Strobe spacing is floor or ceil of `FS_DEN/FS_NUM`: 1684 or 1685 cycles at default. Exactly `FS_NUM` strobes occur per `FS_DEN` cycles.
- First strobe in RUN: `ceil(FS_DEN/FS_NUM)` cycles after entering RUN.
- `in_ready` is combinational from registered count/state; there is no combinational path from `in_valid` to `in_ready`.
- Mute/unmute is sampled at ticks only. Effect is visible on the next strobe's data.

## Configuration
- Macro: `PCM_SOFTMUTE_EN`.
- **Defined:** 7-bit gain register (0..64, reset 64).
  - Each tick: `mute`=1 decrements the gain (floor 0); `mute`=0 increments it (ceiling 64).
  - Output = (sample × gain) >>> 6, signed, 23-bit product truncated to 16.
  - Full ramp takes 64 samples. Gain resets to 64 on IDLE.
- **Undefined:** hard mute. Output is 0/0 on any tick where `mute`=1, otherwise the sample unchanged; no gain register.

## Structure
- Package `pcm_sched_pkg`: state enum (IDLE, PRIME, RUN), sample width constant (16), gain constants (`GAIN_MAX`=64, `GAIN_SHIFT`=6).
- Sub-module `pcm_fs_nco`: fractional accumulator with `FS_NUM`/`FS_DEN` parameters, `run` input, and `tick` output. `run`=0 clears the accumulator.
- Top holds the FSM, 2-entry buffer, mute/gain stage, and underrun flag.

## Test plan
- Reset, then `enable`=1, then supply 2 samples → RUN. First `pcm_fs` arrives 1685 cycles later with the first sample. Over 82540 cycles there are exactly 49 strobes, each spaced 1684 or 1685 cycles.
- Source always valid with an incrementing ramp 0,1,2… → output sequence 0,1,2… with no gaps; `underrun` stays 0.
- Stop the source after priming → the third strobe outputs 0/0, `underrun`=1. Pulse `underrun_clr` → 0. Resuming the source → correct samples follow.
- Assert `mute` with constant 0x4000 input → without the macro, output 0 from the next strobe. With `PCM_SOFTMUTE_EN`, output steps 0x3F00, 0x3E00… reaching 0 after 64 strobes, and ramps back up after release.
- Drop `enable` mid-RUN, including in the tick cycle → no strobe, outputs 0, `in_ready`=0 next cycle. Re-enable → PRIME.
- Assert `reset_n`=0 mid-RUN for one cycle → all outputs at reset values on the following cycle, state IDLE.
